// File: rtl/div_responder.sv
// Multicycle signed restoring divider with a one-cycle result pulse.
// Optional macro DIV_ZERO_EARLY_EN: divide-by-zero skips the loop and answers after one edge.
module div_responder #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_remainder,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH:0]   rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] div_r;
  logic [WIDTH-1:0] a_r;
  logic             neg_q_r;
  logic             zero_r;

  logic [WIDTH:0]   rem_sh_s;
  logic [WIDTH:0]   diff_s;
  logic             borrow_s;
  logic [WIDTH:0]   rem_nx_s;
  logic [WIDTH-1:0] quo_nx_s;

  // Unsigned magnitude; INT_MIN maps to 2^(WIDTH-1), which fits unsigned.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    mag = v[WIDTH-1] ? ({WIDTH{1'b0}} - v) : v;
  endfunction

  // One restoring step: shift in the next dividend bit, trial-subtract the divisor.
  always_comb begin
    rem_sh_s             = {rem_r[WIDTH-1:0], quo_r[WIDTH-1]};
    {borrow_s, diff_s}   = {1'b0, rem_sh_s} - {2'b00, div_r};
    rem_nx_s             = rem_sh_s;
    quo_nx_s             = {quo_r[WIDTH-2:0], 1'b0};
    if (borrow_s) begin
      rem_nx_s = rem_sh_s;
      quo_nx_s = {quo_r[WIDTH-2:0], 1'b0};
    end else begin
      rem_nx_s = diff_s;
      quo_nx_s = {quo_r[WIDTH-2:0], 1'b1};
    end
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r        <= IDLE;
      cnt_r          <= {CW{1'b0}};
      rem_r          <= {(WIDTH+1){1'b0}};
      quo_r          <= {WIDTH{1'b0}};
      div_r          <= {WIDTH{1'b0}};
      a_r            <= {WIDTH{1'b0}};
      neg_q_r        <= 1'b0;
      zero_r         <= 1'b0;
      data_result    <= {WIDTH{1'b0}};
      data_remainder <= {WIDTH{1'b0}};
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      case (state_r)
        IDLE: begin
          busy <= 1'b0;
        end
        RUN: begin
          rem_r <= rem_nx_s;
          quo_r <= quo_nx_s;
          cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          if (cnt_r == LAST) begin
            state_r <= DONE;
          end else begin
            state_r <= RUN;
          end
        end
        DONE: begin
          if (zero_r) begin
            data_result    <= {WIDTH{1'b0}};
            data_remainder <= a_r;
            data_exception <= 1'b1;
          end else begin
            data_result    <= neg_q_r ? ({WIDTH{1'b0}} - quo_r) : quo_r;
            data_remainder <= a_r[WIDTH-1] ? WIDTH'({(WIDTH+1){1'b0}} - rem_r) : WIDTH'(rem_r);
            data_exception <= 1'b0;
          end
          data_resultRDY <= 1'b1;
          busy           <= 1'b0;
          state_r        <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase

      // A strobe in any state (re)starts; in RUN it silently aborts the old request.
      if (ctrl_DIV) begin
        a_r     <= data_operandA;
        quo_r   <= mag(data_operandA);
        div_r   <= mag(data_operandB);
        neg_q_r <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        zero_r  <= (data_operandB == {WIDTH{1'b0}});
        rem_r   <= {(WIDTH+1){1'b0}};
        cnt_r   <= {CW{1'b0}};
        busy    <= 1'b1;
`ifdef DIV_ZERO_EARLY_EN
        state_r <= (data_operandB == {WIDTH{1'b0}}) ? DONE : RUN;
`else
        state_r <= RUN;
`endif
      end
    end
  end

endmodule

// File: tb/tb_div_responder.sv
// Self-checking bench for div_responder: directed corner cases plus random
// requests compared against an arithmetic reference model.
module tb_div_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic [31:0] data_remainder;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int n_compared   = 0;
  int n_mismatched = 0;

  always #5 clock = ~clock;

  div_responder #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_remainder (data_remainder),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: C-style truncating division on 64-bit integers, wrapped to 32 bits.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r,
                                output logic e);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sb == 64'sd0) begin
      q = 32'd0;
      r = a;
      e = 1'b1;
    end else begin
      q = 32'(sa / sb);
      r = 32'(sa % sb);
      e = 1'b0;
    end
  endfunction

  function automatic int exp_latency(input logic [31:0] b);
`ifdef DIV_ZERO_EARLY_EN
    return (b == 32'd0) ? 1 : 33;
`else
    return 33;
`endif
  endfunction

  // Strobe one request; returns just after its E0 edge.
  task automatic start(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_DIV      = 1'b1;
    @(posedge clock);
    #1;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  // Wait (bounded) for the pulse; checks latency, busy and the result.
  task automatic finish(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    logic        e;
    int          n;
    bit          got;
    model(a, b, q, r, e);
    n   = 0;
    got = 1'b0;
    while (!got && n < 60) begin
      @(posedge clock);
      #1;
      n++;
      if (data_resultRDY) got = 1'b1;
      else check("busy_run", busy, 1);
    end
    check("latency", n, exp_latency(b));
    check("quotient", data_result, q);
    check("remainder", data_remainder, r);
    check("exception", data_exception, e);
    check("busy_done", busy, 0);
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b);
    start(a, b);
    finish(a, b);
    @(posedge clock);
    #1;
    check("rdy_clear", data_resultRDY, 0);
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_result"}, data_result, 0);
    check({tag, "_rem"}, data_remainder, 0);
    check({tag, "_exc"}, data_exception, 0);
    check({tag, "_rdy"}, data_resultRDY, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    logic [31:0] a, b;
    bit          b2b;

    reset         = 1'b1;
    ctrl_DIV      = 1'b0;
    data_operandA = 32'd0;
    data_operandB = 32'd0;
    repeat (2) @(posedge clock);
    #1;
    check_idle_zero("reset");
    @(negedge clock);
    reset = 1'b0;

    run(32'd100, 32'd7);
    run(-32'sd7, 32'sd2);
    run(32'sd7, -32'sd2);
    run(32'h8000_0000, 32'hFFFF_FFFF);
    run(32'd5, 32'd0);
    run(32'h8000_0000, 32'd0);
    run(32'h7FFF_FFFF, 32'h8000_0000);
    run(32'h8000_0000, 32'h8000_0000);

    // Restart: second strobe at E10 aborts the first request.
    start(32'd100, 32'd7);
    repeat (9) @(posedge clock);
    start(32'd9, 32'd3);
    finish(32'd9, 32'd3);
    @(posedge clock);
    #1;
    check("restart_rdy_clear", data_resultRDY, 0);

    // Back-to-back: the second strobe lands in the first request's pulse cycle.
    start(32'd20, 32'd3);
    finish(32'd20, 32'd3);
    start(-32'sd100, 32'sd10);
    finish(-32'sd100, 32'sd10);
    @(posedge clock);
    #1;
    check("b2b_rdy_clear", data_resultRDY, 0);

    // Make the held result nonzero, then reset mid-operation at E5.
    run(32'd77, 32'd5);
    start(32'd1000, 32'd3);
    repeat (4) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check_idle_zero("midreset");
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    check("midreset_e6_rdy", data_resultRDY, 0);
    run(32'd1000, 32'd3);

    // Random requests, sometimes chained back-to-back.
    b2b = 1'b0;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'($urandom_range(1, 15));
        3: begin a = 32'h8000_0000; b = $urandom; end
        4: b = {{16{1'b0}}, 16'($urandom)};
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 1) == 0) b = {32{1'b0}} - b;
      start(a, b);
      finish(a, b);
      b2b = ($urandom_range(0, 2) == 0);
      if (!b2b) begin
        @(posedge clock);
        #1;
        check("rand_rdy_clear", data_resultRDY, 0);
      end
    end
    @(posedge clock);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
